// File: rtl/axi_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | axi_arb_pkg                                                            |
// | Channel widths, field offsets and payload structs for the N:1 AXI mux. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package axi_arb_pkg;

  localparam int AR_W = 50;
  localparam int AW_W = 50;
  localparam int W_W  = 37;
  localparam int R_W  = 35;

  localparam int AX_PROT_LSB  = 0;
  localparam int AX_CACHE_LSB = 3;
  localparam int AX_LOCK_LSB  = 7;
  localparam int AX_BURST_LSB = 9;
  localparam int AX_SIZE_LSB  = 11;
  localparam int AX_LEN_LSB   = 14;
  localparam int AX_ADDR_LSB  = 18;

  localparam int W_LAST_LSB = 0;
  localparam int W_STRB_LSB = 1;
  localparam int W_DATA_LSB = 5;

  localparam int R_LAST_LSB = 0;
  localparam int R_RESP_LSB = 1;
  localparam int R_DATA_LSB = 3;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [1:0]  lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
  } ax_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_arb_rr.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | axi_arb_rr                                                             |
// | Round-robin arbiter with hold input and optional master-0 priority.    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module axi_arb_rr #(
  parameter int N       = 3,
  parameter int IW      = 2,
  parameter bit PRIO_EN = 1'b0
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic [N-1:0]  req,
  input  logic          hold,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  localparam logic [IW:0] N_L = (IW+1)'(N);

  logic [IW-1:0] r_ptr;
  logic [IW:0]   w_j;
  logic          w_found;
  logic [IW-1:0] w_idx;

  // Search starts at the pointer and wraps; first requester found wins.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_j     = '0;
    for (int k = 0; k < N; k++) begin
      w_j = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_j >= N_L) w_j = w_j - N_L;
      if (!w_found && req[w_j[IW-1:0]]) begin
        w_found = 1'b1;
        w_idx   = w_j[IW-1:0];
      end
    end
    if (PRIO_EN && req[0]) begin
      w_found = 1'b1;
      w_idx   = '0;
    end
  end

  assign grant_valid = w_found && !hold;
  assign grant_idx   = w_idx;

  always_comb begin
    grant = '0;
    if (grant_valid) grant[w_idx] = 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_ptr <= '0;
    end else if (grant_valid) begin
      r_ptr <= (w_idx == IW'(N - 1)) ? '0 : w_idx + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_nto1_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | axi_nto1_arbiter                                                       |
// | N-to-1 AXI3 master mux: RR AR/AW arbitration, ID extension, W steering.|
// | Build option: AXI_ARB_PRIO_EN gives master 0 strict AR/AW priority.    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module axi_nto1_arbiter
  import axi_arb_pkg::*;
#(
  parameter int N_MASTERS = 3,
  parameter int ID_W      = 4,
  parameter int WQ_DEPTH  = 4,
  localparam int IDX_W    = (clog2(N_MASTERS) < 1) ? 1 : clog2(N_MASTERS),
  localparam int MID_W    = ID_W + IDX_W
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [N_MASTERS-1:0]        s_arvalid,
  output logic [N_MASTERS-1:0]        s_arready,
  input  logic [N_MASTERS*ID_W-1:0]   s_arid,
  input  logic [N_MASTERS*AR_W-1:0]   s_ar,
  input  logic [N_MASTERS-1:0]        s_awvalid,
  output logic [N_MASTERS-1:0]        s_awready,
  input  logic [N_MASTERS*ID_W-1:0]   s_awid,
  input  logic [N_MASTERS*AW_W-1:0]   s_aw,
  input  logic [N_MASTERS-1:0]        s_wvalid,
  output logic [N_MASTERS-1:0]        s_wready,
  input  logic [N_MASTERS*ID_W-1:0]   s_wid,
  input  logic [N_MASTERS*W_W-1:0]    s_w,
  output logic [N_MASTERS-1:0]        s_rvalid,
  input  logic [N_MASTERS-1:0]        s_rready,
  output logic [ID_W-1:0]             s_rid,
  output logic [R_W-1:0]              s_r,
  output logic [N_MASTERS-1:0]        s_bvalid,
  input  logic [N_MASTERS-1:0]        s_bready,
  output logic [ID_W-1:0]             s_bid,
  output logic [1:0]                  s_bresp,
  output logic                        m_arvalid,
  input  logic                        m_arready,
  output logic [MID_W-1:0]            m_arid,
  output logic [31:0]                 m_araddr,
  output logic [3:0]                  m_arlen,
  output logic [2:0]                  m_arsize,
  output logic [1:0]                  m_arburst,
  output logic [1:0]                  m_arlock,
  output logic [3:0]                  m_arcache,
  output logic [2:0]                  m_arprot,
  output logic                        m_awvalid,
  input  logic                        m_awready,
  output logic [MID_W-1:0]            m_awid,
  output logic [31:0]                 m_awaddr,
  output logic [3:0]                  m_awlen,
  output logic [2:0]                  m_awsize,
  output logic [1:0]                  m_awburst,
  output logic [1:0]                  m_awlock,
  output logic [3:0]                  m_awcache,
  output logic [2:0]                  m_awprot,
  output logic                        m_wvalid,
  input  logic                        m_wready,
  output logic [MID_W-1:0]            m_wid,
  output logic [31:0]                 m_wdata,
  output logic [3:0]                  m_wstrb,
  output logic                        m_wlast,
  input  logic                        m_rvalid,
  output logic                        m_rready,
  input  logic [MID_W-1:0]            m_rid,
  input  logic [31:0]                 m_rdata,
  input  logic [1:0]                  m_rresp,
  input  logic                        m_rlast,
  input  logic                        m_bvalid,
  output logic                        m_bready,
  input  logic [MID_W-1:0]            m_bid,
  input  logic [1:0]                  m_bresp
);

`ifdef AXI_ARB_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  localparam int PTR_W = clog2(WQ_DEPTH);

  ax_t             w_ar_a   [N_MASTERS];
  ax_t             w_aw_a   [N_MASTERS];
  w_t              w_w_a    [N_MASTERS];
  logic [ID_W-1:0] w_arid_a [N_MASTERS];
  logic [ID_W-1:0] w_awid_a [N_MASTERS];
  logic [ID_W-1:0] w_wid_a  [N_MASTERS];

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_unpack
    assign w_ar_a[i]   = s_ar[i*AR_W +: AR_W];
    assign w_aw_a[i]   = s_aw[i*AW_W +: AW_W];
    assign w_w_a[i]    = s_w[i*W_W +: W_W];
    assign w_arid_a[i] = s_arid[i*ID_W +: ID_W];
    assign w_awid_a[i] = s_awid[i*ID_W +: ID_W];
    assign w_wid_a[i]  = s_wid[i*ID_W +: ID_W];
  end

  // ---------------- AR ----------------
  logic             r_ar_valid;
  logic [MID_W-1:0] r_ar_id;
  ax_t              r_ar;
  logic             w_ar_hold;
  logic             w_ar_gv;
  logic [IDX_W-1:0] w_ar_idx;

  assign w_ar_hold = r_ar_valid && !m_arready;

  axi_arb_rr #(.N(N_MASTERS), .IW(IDX_W), .PRIO_EN(PRIO_EN)) u_ar_arb (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .req         (s_arvalid),
    .hold        (w_ar_hold),
    .grant       (s_arready),
    .grant_idx   (w_ar_idx),
    .grant_valid (w_ar_gv)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_ar_valid <= 1'b0;
      r_ar_id    <= '0;
      r_ar       <= '0;
    end else if (w_ar_gv) begin
      r_ar_valid <= 1'b1;
      r_ar_id    <= {w_ar_idx, w_arid_a[w_ar_idx]};
      r_ar       <= w_ar_a[w_ar_idx];
    end else if (m_arready) begin
      r_ar_valid <= 1'b0;
    end
  end

  assign m_arvalid = r_ar_valid;
  assign m_arid    = r_ar_id;
  assign m_araddr  = r_ar.addr;
  assign m_arlen   = r_ar.len;
  assign m_arsize  = r_ar.size;
  assign m_arburst = r_ar.burst;
  assign m_arlock  = r_ar.lock;
  assign m_arcache = r_ar.cache;
  assign m_arprot  = r_ar.prot;

  // ---------------- AW + steering queue ----------------
  logic             r_aw_valid;
  logic [MID_W-1:0] r_aw_id;
  ax_t              r_aw;
  logic             w_aw_hold;
  logic             w_aw_gv;
  logic [IDX_W-1:0] w_aw_idx;

  logic [IDX_W-1:0] r_wq [WQ_DEPTH];
  logic [PTR_W:0]   r_wq_wr;
  logic [PTR_W:0]   r_wq_rd;
  logic             w_wq_empty;
  logic             w_wq_full;
  logic             w_wq_pop;
  logic [IDX_W-1:0] w_head;

  assign w_wq_empty = (r_wq_wr == r_wq_rd);
  assign w_wq_full  = (r_wq_wr[PTR_W] != r_wq_rd[PTR_W]) &&
                      (r_wq_wr[PTR_W-1:0] == r_wq_rd[PTR_W-1:0]);

  // Full is judged before this cycle's pop so a push never races a pop.
  assign w_aw_hold = (r_aw_valid && !m_awready) || w_wq_full;

  axi_arb_rr #(.N(N_MASTERS), .IW(IDX_W), .PRIO_EN(PRIO_EN)) u_aw_arb (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .req         (s_awvalid),
    .hold        (w_aw_hold),
    .grant       (s_awready),
    .grant_idx   (w_aw_idx),
    .grant_valid (w_aw_gv)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_aw_valid <= 1'b0;
      r_aw_id    <= '0;
      r_aw       <= '0;
    end else if (w_aw_gv) begin
      r_aw_valid <= 1'b1;
      r_aw_id    <= {w_aw_idx, w_awid_a[w_aw_idx]};
      r_aw       <= w_aw_a[w_aw_idx];
    end else if (m_awready) begin
      r_aw_valid <= 1'b0;
    end
  end

  assign m_awvalid = r_aw_valid;
  assign m_awid    = r_aw_id;
  assign m_awaddr  = r_aw.addr;
  assign m_awlen   = r_aw.len;
  assign m_awsize  = r_aw.size;
  assign m_awburst = r_aw.burst;
  assign m_awlock  = r_aw.lock;
  assign m_awcache = r_aw.cache;
  assign m_awprot  = r_aw.prot;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wq_wr <= '0;
      r_wq_rd <= '0;
      for (int i = 0; i < WQ_DEPTH; i++) r_wq[i] <= '0;
    end else begin
      if (w_aw_gv) begin
        r_wq[r_wq_wr[PTR_W-1:0]] <= w_aw_idx;
        r_wq_wr                  <= r_wq_wr + 1'b1;
      end
      if (w_wq_pop) r_wq_rd <= r_wq_rd + 1'b1;
    end
  end

  // ---------------- W steering ----------------
  assign w_head   = r_wq[r_wq_rd[PTR_W-1:0]];
  assign w_wq_pop = m_wvalid && m_wready && m_wlast;

  always_comb begin
    s_wready = '0;
    m_wvalid = 1'b0;
    m_wid    = '0;
    m_wdata  = '0;
    m_wstrb  = '0;
    m_wlast  = 1'b0;
    if (!w_wq_empty) begin
      m_wvalid         = s_wvalid[w_head];
      m_wid            = {w_head, w_wid_a[w_head]};
      m_wdata          = w_w_a[w_head].data;
      m_wstrb          = w_w_a[w_head].strb;
      m_wlast          = w_w_a[w_head].last;
      s_wready[w_head] = m_wready;
    end
  end

  // ---------------- R / B routing ----------------
  logic [IDX_W-1:0] w_r_sel;
  logic [IDX_W-1:0] w_b_sel;

  assign w_r_sel = m_rid[MID_W-1 -: IDX_W];
  assign w_b_sel = m_bid[MID_W-1 -: IDX_W];

  // Responses tagged with a nonexistent source are sunk so the bus never stalls.
  always_comb begin
    s_rvalid = '0;
    m_rready = 1'b1;
    if (int'(w_r_sel) < N_MASTERS) begin
      s_rvalid[w_r_sel] = m_rvalid;
      m_rready          = s_rready[w_r_sel];
    end
  end

  always_comb begin
    s_bvalid = '0;
    m_bready = 1'b1;
    if (int'(w_b_sel) < N_MASTERS) begin
      s_bvalid[w_b_sel] = m_bvalid;
      m_bready          = s_bready[w_b_sel];
    end
  end

  assign s_rid   = m_rid[ID_W-1:0];
  assign s_r     = {m_rdata, m_rresp, m_rlast};
  assign s_bid   = m_bid[ID_W-1:0];
  assign s_bresp = m_bresp;

endmodule
`default_nettype wire

// File: tb/tb_axi_nto1_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_axi_nto1_arbiter                                                    |
// | Directed scoreboard bench for axi_nto1_arbiter (3 masters, ID_W=4).    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_axi_nto1_arbiter;

  logic         aclk    = 1'b0;
  logic         aresetn = 1'b0;

  logic [2:0]   s_arvalid = '0;
  logic [2:0]   s_arready;
  logic [11:0]  s_arid    = '0;
  logic [149:0] s_ar      = '0;
  logic [2:0]   s_awvalid = '0;
  logic [2:0]   s_awready;
  logic [11:0]  s_awid    = '0;
  logic [149:0] s_aw      = '0;
  logic [2:0]   s_wvalid  = '0;
  logic [2:0]   s_wready;
  logic [11:0]  s_wid     = '0;
  logic [110:0] s_w       = '0;
  logic [2:0]   s_rvalid;
  logic [2:0]   s_rready  = '0;
  logic [3:0]   s_rid;
  logic [34:0]  s_r;
  logic [2:0]   s_bvalid;
  logic [2:0]   s_bready  = '0;
  logic [3:0]   s_bid;
  logic [1:0]   s_bresp;

  logic        m_arvalid;
  logic        m_arready = 1'b0;
  logic [5:0]  m_arid;
  logic [31:0] m_araddr;
  logic [3:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic [1:0]  m_arlock;
  logic [3:0]  m_arcache;
  logic [2:0]  m_arprot;
  logic        m_awvalid;
  logic        m_awready = 1'b0;
  logic [5:0]  m_awid;
  logic [31:0] m_awaddr;
  logic [3:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst;
  logic [1:0]  m_awlock;
  logic [3:0]  m_awcache;
  logic [2:0]  m_awprot;
  logic        m_wvalid;
  logic        m_wready = 1'b0;
  logic [5:0]  m_wid;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wlast;
  logic        m_rvalid = 1'b0;
  logic        m_rready;
  logic [5:0]  m_rid    = '0;
  logic [31:0] m_rdata  = '0;
  logic [1:0]  m_rresp  = '0;
  logic        m_rlast  = 1'b0;
  logic        m_bvalid = 1'b0;
  logic        m_bready;
  logic [5:0]  m_bid    = '0;
  logic [1:0]  m_bresp  = '0;

  axi_nto1_arbiter #(.N_MASTERS(3), .ID_W(4), .WQ_DEPTH(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_ar(s_ar),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_aw(s_aw),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wid(s_wid), .s_w(s_w),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_r(s_r),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arlock(m_arlock),
    .m_arcache(m_arcache), .m_arprot(m_arprot),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awlock(m_awlock),
    .m_awcache(m_awcache), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wid(m_wid), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp)
  );

  always #5 aclk = ~aclk;

  int n_vec = 0;
  int n_err = 0;

  // Expected downstream transfers: AR/AW = {id6, addr32, len4}, W = {id6, data32, strb4, last}
  logic [41:0] ar_exp [$];
  logic [41:0] aw_exp [$];
  logic [42:0] w_exp  [$];
  // Per-master W beats still to be offered: {id4, data32, strb4, last}
  logic [40:0] wbeat [3][$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitors ----------------
  logic [41:0] mon_ax;
  logic [42:0] mon_w;

  always @(negedge aclk) begin
    if (aresetn && m_arvalid && m_arready) begin
      check("ar_expected_pending", 64'(ar_exp.size() != 0), 64'd1);
      if (ar_exp.size() != 0) begin
        mon_ax = ar_exp.pop_front();
        check("ar_beat", 64'({m_arid, m_araddr, m_arlen}), 64'(mon_ax));
      end
    end
    if (aresetn && m_awvalid && m_awready) begin
      check("aw_expected_pending", 64'(aw_exp.size() != 0), 64'd1);
      if (aw_exp.size() != 0) begin
        mon_ax = aw_exp.pop_front();
        check("aw_beat", 64'({m_awid, m_awaddr, m_awlen}), 64'(mon_ax));
      end
    end
    if (aresetn && m_wvalid && m_wready) begin
      check("w_expected_pending", 64'(w_exp.size() != 0), 64'd1);
      if (w_exp.size() != 0) begin
        mon_w = w_exp.pop_front();
        check("w_beat", 64'({m_wid, m_wdata, m_wstrb, m_wlast}), 64'(mon_w));
      end
    end
  end

  // ---------------- W source driver ----------------
  initial begin : w_driver
    logic [2:0] hs;
    forever begin
      @(negedge aclk);
      hs = s_wvalid & s_wready;
      @(posedge aclk);
      #1;
      for (int m = 0; m < 3; m++) begin
        if (hs[m]) void'(wbeat[m].pop_front());
        s_wvalid[m] = (wbeat[m].size() != 0);
        if (wbeat[m].size() != 0) begin
          s_wid[m*4 +: 4]  = wbeat[m][0][40:37];
          s_w[m*37 +: 37]  = wbeat[m][0][36:0];
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic ar_set(input int m, input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
    s_arvalid[m]       = 1'b1;
    s_arid[m*4 +: 4]   = id;
    s_ar[m*50 +: 50]   = {addr, len, 3'd2, 2'd1, 2'd0, 4'd3, 3'd0};
  endtask

  task automatic aw_set(input int m, input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
    s_awvalid[m]       = 1'b1;
    s_awid[m*4 +: 4]   = id;
    s_aw[m*50 +: 50]   = {addr, len, 3'd2, 2'd1, 2'd0, 4'd3, 3'd0};
  endtask

  task automatic w_add(input int m, input logic [3:0] id, input logic [31:0] data, input logic last);
    wbeat[m].push_back({id, data, 4'hf, last});
    w_exp.push_back({2'(m), id, data, 4'hf, last});
  endtask

  task automatic ar_drain();
    logic [2:0] hs;
    int cyc;
    cyc = 0;
    while (s_arvalid != 0 && cyc < 20) begin
      @(negedge aclk);
      hs = s_arvalid & s_arready;
      @(posedge aclk);
      #1;
      s_arvalid = s_arvalid & ~hs;
      cyc++;
    end
    check("ar_accept_timeout", 64'(s_arvalid), 64'd0);
  endtask

  task automatic aw_drain();
    logic [2:0] hs;
    int cyc;
    cyc = 0;
    while (s_awvalid != 0 && cyc < 20) begin
      @(negedge aclk);
      hs = s_awvalid & s_awready;
      @(posedge aclk);
      #1;
      s_awvalid = s_awvalid & ~hs;
      cyc++;
    end
    check("aw_accept_timeout", 64'(s_awvalid), 64'd0);
  endtask

  task automatic wait_empty(input string name);
    int cyc;
    cyc = 0;
    while ((ar_exp.size() + aw_exp.size() + w_exp.size()) != 0 && cyc < 60) begin
      @(posedge aclk);
      cyc++;
    end
    check(name, 64'(ar_exp.size() + aw_exp.size() + w_exp.size()), 64'd0);
    @(posedge aclk);
    #1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin : stim
    logic [2:0] hs;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_m_arvalid", 64'(m_arvalid), 64'd0);
    check("rst_m_awvalid", 64'(m_awvalid), 64'd0);
    check("rst_m_wvalid",  64'(m_wvalid),  64'd0);
    check("rst_m_arid",    64'(m_arid),    64'd0);
    check("rst_m_awaddr",  64'(m_awaddr),  64'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // AR: three simultaneous requests, round-robin from pointer 0
    m_arready = 1'b1;
    ar_set(0, 4'h1, 32'h0000_1000, 4'd0);
    ar_set(1, 4'h2, 32'h0000_2000, 4'd1);
    ar_set(2, 4'h3, 32'h0000_3000, 4'd2);
    ar_exp.push_back({2'd0, 4'h1, 32'h0000_1000, 4'd0});
    ar_exp.push_back({2'd1, 4'h2, 32'h0000_2000, 4'd1});
    ar_exp.push_back({2'd2, 4'h3, 32'h0000_3000, 4'd2});
    @(negedge aclk);
    check("ar_lat_before", 64'(m_arvalid), 64'd0);
    check("ar_first_grant", 64'(s_arready), 64'b001);
    hs = s_arvalid & s_arready;
    @(posedge aclk);
    #1;
    s_arvalid = s_arvalid & ~hs;
    @(negedge aclk);
    check("ar_lat_after", 64'(m_arvalid), 64'd1);
    check("ar_second_grant", 64'(s_arready), 64'b010);
    hs = s_arvalid & s_arready;
    @(posedge aclk);
    #1;
    s_arvalid = s_arvalid & ~hs;
    ar_drain();
    wait_empty("ar_rr_drain");

    // AR stall: master 1 held in output register, master 2 must wait
    m_arready = 1'b0;
    ar_set(1, 4'h5, 32'h0001_0040, 4'd3);
    ar_exp.push_back({2'd1, 4'h5, 32'h0001_0040, 4'd3});
    ar_drain();
    ar_set(2, 4'h6, 32'h0002_0080, 4'd1);
    ar_exp.push_back({2'd2, 4'h6, 32'h0002_0080, 4'd1});
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      check("ar_hold_id",    64'(m_arid),    64'({2'd1, 4'h5}));
      check("ar_hold_addr",  64'(m_araddr),  64'h0001_0040);
      check("ar_hold_ready", 64'(s_arready), 64'd0);
      @(posedge aclk);
    end
    #1;
    m_arready = 1'b1;
    ar_drain();
    wait_empty("ar_stall_drain");

    // W steering: W offered before AW, then AW from master 2 (len 3) and master 0 (len 0)
    m_awready = 1'b1;
    m_wready  = 1'b1;
    w_add(2, 4'h7, 32'hC000_0000, 1'b0);
    w_add(2, 4'h7, 32'hC000_0001, 1'b0);
    w_add(2, 4'h7, 32'hC000_0002, 1'b0);
    w_add(2, 4'h7, 32'hC000_0003, 1'b1);
    w_add(0, 4'h1, 32'hA000_0000, 1'b1);
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("w_empty_q_valid", 64'(m_wvalid), 64'd0);
    check("w_empty_q_ready", 64'(s_wready), 64'd0);
    @(posedge aclk);
    #1;
    aw_set(2, 4'h7, 32'h0000_8000, 4'd3);
    aw_exp.push_back({2'd2, 4'h7, 32'h0000_8000, 4'd3});
    aw_drain();
    aw_set(0, 4'h1, 32'h0000_9000, 4'd0);
    aw_exp.push_back({2'd0, 4'h1, 32'h0000_9000, 4'd0});
    aw_drain();
    for (int k = 0; k < 40 && w_exp.size() > 1; k++) begin
      @(negedge aclk);
      if (w_exp.size() > 1) check("w_m0_blocked", 64'(s_wready[0]), 64'd0);
    end
    wait_empty("w_steer_drain");

    // Queue full: four AWs without W fill the steering queue, the fifth waits for a pop
    for (int k = 0; k < 4; k++) begin
      aw_set(1, 4'h2, 32'h3000_0000 + 32'(k * 16), 4'd0);
      aw_exp.push_back({2'd1, 4'h2, 32'h3000_0000 + 32'(k * 16), 4'd0});
      aw_drain();
    end
    aw_set(1, 4'h2, 32'h3000_0040, 4'd0);
    aw_exp.push_back({2'd1, 4'h2, 32'h3000_0040, 4'd0});
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      check("aw_full_ready", 64'(s_awready), 64'd0);
      @(posedge aclk);
    end
    #1;
    w_add(1, 4'h2, 32'hB000_0000, 1'b1);
    aw_drain();
    for (int k = 1; k < 5; k++) w_add(1, 4'h2, 32'hB000_0000 + 32'(k), 1'b1);
    wait_empty("aw_full_drain");

    // R/B routing and discard of out-of-range source index
    m_rvalid = 1'b1;
    m_rid    = 6'b11_0101;
    m_rdata  = 32'hDEAD_BEEF;
    m_rresp  = 2'b10;
    m_rlast  = 1'b1;
    s_rready = 3'b000;
    #1;
    check("r_discard_ready", 64'(m_rready), 64'd1);
    check("r_discard_valid", 64'(s_rvalid), 64'd0);
    m_rid    = {2'b01, 4'h9};
    s_rready = 3'b010;
    #1;
    check("r_route_valid", 64'(s_rvalid), 64'b010);
    check("r_route_ready", 64'(m_rready), 64'd1);
    check("r_route_id",    64'(s_rid),    64'h9);
    check("r_route_data",  64'(s_r),      64'({32'hDEAD_BEEF, 2'b10, 1'b1}));
    s_rready = 3'b101;
    #1;
    check("r_route_backpr", 64'(m_rready), 64'd0);
    m_rvalid = 1'b0;
    m_bvalid = 1'b1;
    m_bid    = {2'b10, 4'h3};
    m_bresp  = 2'b01;
    s_bready = 3'b100;
    #1;
    check("b_route_valid", 64'(s_bvalid), 64'b100);
    check("b_route_ready", 64'(m_bready), 64'd1);
    check("b_route_id",    64'(s_bid),    64'h3);
    check("b_route_resp",  64'(s_bresp),  64'h1);
    m_bid    = 6'b11_0000;
    s_bready = 3'b000;
    #1;
    check("b_discard_ready", 64'(m_bready), 64'd1);
    check("b_discard_valid", 64'(s_bvalid), 64'd0);
    m_bvalid = 1'b0;
    @(posedge aclk);
    #1;

    // Masters 0 and 1 requesting continuously for four grants
    ar_set(0, 4'hA, 32'h4000_0000, 4'd0);
    ar_set(1, 4'hB, 32'h5000_0000, 4'd0);
    for (int k = 0; k < 4; k++) begin
`ifdef AXI_ARB_PRIO_EN
      ar_exp.push_back({2'd0, 4'hA, 32'h4000_0000, 4'd0});
`else
      if (k % 2 == 0) ar_exp.push_back({2'd0, 4'hA, 32'h4000_0000, 4'd0});
      else            ar_exp.push_back({2'd1, 4'hB, 32'h5000_0000, 4'd0});
`endif
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
`ifdef AXI_ARB_PRIO_EN
      check("arb_prio_grant", 64'(s_arready), 64'b001);
`else
      check("arb_rr_grant", 64'(s_arready), (k % 2 == 0) ? 64'b001 : 64'b010);
`endif
      @(posedge aclk);
    end
    #1;
    s_arvalid = '0;
    wait_empty("arb_contend_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_nto1_arbiter.md
# axi_nto1_arbiter

Parametrised N-to-1 AXI3 master multiplexer that merges the CPU's per-source AXI master ports (icache, dcache, uncached, or any count) onto a single AXI3 master port toward the SoC interconnect. Independent round-robin arbitration for AR and AW, ID extension with source index for response routing, and an in-order W-channel steering queue. It sits directly behind the CPU core and replaces three separate interconnect slave ports with one.

## Interface
- N_MASTERS, 3, number of upstream masters (1..8)
- ID_W, 4, upstream ID width; downstream ID width is ID_W+IDX_W, IDX_W=max(1,clog2(N_MASTERS))
- WQ_DEPTH, 4, outstanding-write steering queue depth (power of two, >=2)
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_arvalid / s_arready  in / out  N  per-master AR handshake
- s_arid  in  N*ID_W  per-master AR ID
- s_ar  in  N*AR_W  packed {addr[31:0],len[3:0],size[2:0],burst[1:0],lock[1:0],cache[3:0],prot[2:0]}, AR_W=50
- s_awvalid / s_awready / s_awid / s_aw  same shapes as AR, AW_W=50
- s_wvalid / s_wready  in / out  N  per-master W handshake
- s_wid  in  N*ID_W;  s_w  in  N*37  packed {data[31:0],strb[3:0],last}
- s_rvalid / s_rready  out / in  N;  s_rid  out ID_W;  s_r  out 35 {data,resp,last}, broadcast
- s_bvalid / s_bready  out / in  N;  s_bid  out ID_W;  s_bresp  out 2, broadcast
- m_ar*, m_aw*, m_w*, m_r*, m_b*  mirror of one master with IDs ID_W+IDX_W wide, unpacked standard AXI3 names (m_araddr, m_arlen, ...)

## Operation
- AR path: round-robin arbiter over s_arvalid; winner loaded into 1-entry output register; m_arid={idx,s_arid[idx]}. Register accepts when empty or m_arready in same cycle; s_arready[idx] high only for the winner in that cycle.
- AW path: identical, plus push idx into steering FIFO on acceptance; FIFO full forces all s_awready=0.
- W path: FIFO head selects source; m_w*=s_w*[head], m_wid={head,s_wid[head]}; s_wready[head]=m_wready, others 0. Pop on m_wvalid&m_wready&m_wlast. FIFO empty: m_wvalid=0, all s_wready=0 (W ahead of AW stalls).
- R/B path: combinational demux on upper IDX_W ID bits; s_rvalid[sel]=m_rvalid, m_rready=s_rready[sel]. sel>=N_MASTERS: m_rready/m_bready=1, response discarded.
- Arbiter pointer advances to winner+1 (mod N) only on acceptance; no grant change while output register holds an unaccepted request (AXI stability).

## Timing
- Reset: all *valid, *ready, payloads, IDs =0; RR pointers=0; FIFO empty.
- AR/AW latency: s_*valid accepted cycle t -> m_*valid cycle t+1. Back-to-back one per cycle when m_*ready held high.
- W, R, B: zero-cycle combinational pass-through.
- Simultaneous AW push and W pop on full FIFO: push refused that cycle (full evaluated pre-pop).
- Reset asserted mid-burst: FIFO cleared, in-flight bursts abandoned; downstream reset is assumed shared.

## Configuration
- AXI_ARB_PRIO_EN: defined -> master 0 has strict priority on AR and AW, remaining masters round-robin among themselves. Undefined -> plain round-robin over all masters.

## Structure
- Package axi_arb_pkg: AR_W, AW_W, W_W, R_W, field offset localparams, packed struct typedefs for AR/W/R payloads, clog2 function.
- Sub-module axi_arb_rr: N-request round-robin arbiter with hold input and optional priority override, instanced twice (AR, AW). Steering FIFO inline.

## Test plan
- Masters 0,1,2 assert AR together, m_arready=1 -> m_arid upper bits 0,1,2 on consecutive cycles, first at t+1.
- m_arready=0 for 5 cycles with master 1 pending, master 2 raises AR -> m_ar* stable, grant stays master 1.
- AW from master 2 (len=3) then master 0 (len=0) -> W beats forwarded 4 from master 2 then 1 from master 0; master 0 s_wready=0 until master 2 wlast.
- WQ_DEPTH=4, five AW with no W -> fifth s_awready=0 until first wlast pop.
- m_rid=6'b11_0101 with N_MASTERS=3 -> m_rready=1, all s_rvalid=0.
- Macro defined, masters 0 and 1 continuously requesting -> master 0 wins every grant.
